// File: rtl/axi_write_master_if.sv
// AXI3 write channel bundle (AW, W, B) between the write master and a slave.
interface axi_write_master_if #(
    parameter int unsigned BUSWIDTH = 32
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned STRB_W = 4;

    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [ID_W-1:0]     WID;
    logic [BUSWIDTH-1:0] WDATA;
    logic [STRB_W-1:0]   WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_write_master.sv
// Single-outstanding AXI3 INCR write master: takes one burst request from the
// device, issues AW, streams beats through a one-entry W holding stage, and
// reports the B response as a one-cycle done pulse.
module axi_write_master #(
    parameter int unsigned BUSWIDTH = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic [3:0]          req_len,
    input  logic [3:0]          req_id,
    input  logic [BUSWIDTH-1:0] wr_data,
    input  logic [3:0]          wr_strb,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic                done,
    output logic [1:0]          done_resp,
    axi_write_master_if.master  axi
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned STRB_W = 4;

    localparam logic [2:0] AXSIZE_4B  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_SLV   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } req_t;

    state_t            state_q;
    state_t            state_d;
    req_t              req_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  load_idx;

    logic req_fire;
    logic aw_fire;
    logic w_fire;
    logic load;
    logic b_fire;

    assign req_fire = req_valid & req_ready;
    assign aw_fire  = axi.AWVALID & axi.AWREADY;
    assign w_fire   = axi.WVALID & axi.WREADY;
    assign load     = wr_valid & wr_ready;
    assign b_fire   = axi.BVALID & axi.BREADY;

    // Beat index entering the holding stage: one ahead when the current beat drains.
    assign load_idx = beat_cnt + LEN_W'(axi.WVALID);

    // AW fields and WID come straight from the captured request registers.
    assign axi.AWID    = req_q.id;
    assign axi.AWADDR  = req_q.addr;
    assign axi.AWLEN   = req_q.len;
    assign axi.AWSIZE  = AXSIZE_4B;
    assign axi.AWBURST = BURST_INCR;
    assign axi.WID     = req_q.id;

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake-ready decode; a request is refused while done pulses.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        axi.BREADY = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = !done;
                if (req_valid && !done) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (aw_fire) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                wr_ready = !(axi.WVALID && axi.WLAST) && (!axi.WVALID || axi.WREADY);
                if (w_fire && axi.WLAST) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                axi.BREADY = 1'b1;
                if (axi.BVALID) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, AW valid, W holding stage, beat counter and response capture.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            req_q       <= '0;
            beat_cnt    <= '0;
            axi.AWVALID <= 1'b0;
            axi.WVALID  <= 1'b0;
            axi.WLAST   <= 1'b0;
            axi.WDATA   <= '0;
            axi.WSTRB   <= '0;
            done        <= 1'b0;
            done_resp   <= '0;
        end else begin
            done <= 1'b0;

            if (req_fire) begin
                req_q       <= '{addr: req_addr, len: req_len, id: req_id};
                beat_cnt    <= '0;
                axi.AWVALID <= 1'b1;
            end else if (aw_fire) begin
                axi.AWVALID <= 1'b0;
            end

            // The counter parks on len after the last beat instead of wrapping.
            if (w_fire && !axi.WLAST) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
            end

            if (load) begin
                axi.WDATA  <= wr_data;
                axi.WSTRB  <= STRB_W'(wr_strb);
                axi.WLAST  <= (load_idx == req_q.len);
                axi.WVALID <= 1'b1;
            end else if (w_fire) begin
                axi.WVALID <= 1'b0;
                axi.WLAST  <= 1'b0;
            end

            // A response for another ID is reported as a slave error.
            if (b_fire) begin
                done      <= 1'b1;
                done_resp <= (axi.BID != req_q.id) ? RESP_SLV : axi.BRESP;
            end
        end
    end

endmodule
